// File: rtl/regfile_dump_ctrl.sv
// Register-file dump sequencer: stalls the pipeline, drains writeback, then streams every register
// out over valid/ready. Optional trailing XOR checksum beat under REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump_ctrl #(
    parameter int unsigned NB_REG       = 5,
    parameter int unsigned NB_DATA      = 32,
    parameter int unsigned N_REGISTER   = 32,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [NB_REG-1:0]  addr_ra_i,
    input  logic [NB_REG-1:0]  addr_rb_i,
    input  logic               wb_rw_i,
    input  logic [NB_REG-1:0]  wb_addr_i,
    input  logic [NB_DATA-1:0] wb_data_i,
    output logic               rf_rw_o,
    output logic [NB_REG-1:0]  rf_addr_ra_o,
    output logic [NB_REG-1:0]  rf_addr_rb_o,
    output logic [NB_REG-1:0]  rf_addr_rw_o,
    output logic [NB_DATA-1:0] rf_data_rw_o,
    input  logic [NB_DATA-1:0] rf_data_ra_i,
    input  logic               dump_req_i,
    input  logic               dump_ready_i,
    output logic               dump_valid_o,
    output logic [NB_REG:0]    dump_addr_o,
    output logic [NB_DATA-1:0] dump_data_o,
    output logic               stall_o,
    output logic               busy_o,
    output logic               dump_done_o
);

    localparam int unsigned NB_IDX   = NB_REG + 1;
    localparam int unsigned NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StDrain   = 3'd1;
    localparam logic [2:0] StIssue   = 3'd2;
    localparam logic [2:0] StCapture = 3'd3;
    localparam logic [2:0] StSend    = 3'd4;
    localparam logic [2:0] StDone    = 3'd5;

    localparam logic [NB_IDX-1:0]   LastIdx   = NB_IDX'(N_REGISTER - 1);
    localparam logic [NB_DRAIN-1:0] DrainLast = NB_DRAIN'(DRAIN_CYCLES - 1);

    logic [2:0]          state_q, state_d;
    logic [NB_IDX-1:0]   index_q, index_d;
    logic [NB_DRAIN-1:0] drain_cnt_q, drain_cnt_d;
    logic                valid_q, valid_d;
    logic [NB_IDX-1:0]   addr_q, addr_d;
    logic [NB_DATA-1:0]  data_q, data_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam logic [NB_IDX-1:0] CsumIdx = NB_IDX'(N_REGISTER);
    logic [NB_DATA-1:0]  csum_q, csum_d;
`endif

    // Writes always reach the bank so in-flight writeback can drain during the stall.
    assign rf_rw_o      = wb_rw_i;
    assign rf_addr_rw_o = wb_addr_i;
    assign rf_data_rw_o = wb_data_i;
    assign rf_addr_rb_o = addr_rb_i;
    assign rf_addr_ra_o = ((state_q == StIdle) || (state_q == StDone)) ? addr_ra_i
                                                                       : index_q[NB_REG-1:0];

    assign dump_valid_o = valid_q;
    assign dump_addr_o  = addr_q;
    assign dump_data_o  = data_q;
    assign busy_o       = (state_q != StIdle);
    assign stall_o      = (state_q != StIdle) && (state_q != StDone);
    assign dump_done_o  = (state_q == StDone);

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        drain_cnt_d = drain_cnt_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (dump_req_i) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                    index_d     = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    csum_d      = '0;
`endif
                end
            end
            StDrain: begin
                if (drain_cnt_q == DrainLast) begin
                    state_d = StIssue;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            StIssue: begin
                state_d = StCapture;
            end
            StCapture: begin
                // A write landing now may target the register just read; read it again.
                if (wb_rw_i) begin
                    state_d = StIssue;
                end else begin
                    valid_d = 1'b1;
                    addr_d  = index_q;
                    data_d  = rf_data_ra_i;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (dump_ready_i) begin
                    valid_d = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    csum_d  = csum_q ^ data_q;
                    if (index_q == LastIdx) begin
                        // Checksum beat goes out straight away, no bank read needed.
                        index_d = CsumIdx;
                        valid_d = 1'b1;
                        addr_d  = CsumIdx;
                        data_d  = csum_q ^ data_q;
                    end else if (index_q == CsumIdx) begin
                        state_d = StDone;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = StIssue;
                    end
`else
                    if (index_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = StIssue;
                    end
`endif
                end
            end
            StDone: begin
                index_d = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q     <= StIdle;
            index_q     <= '0;
            drain_cnt_q <= '0;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            drain_cnt_q <= drain_cnt_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule
